// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - register offsets, STATUS bit positions and FSM states for the MMIO UART transmitter
package uart_tx_pkg;

    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_DIV    = 4'h8;
    localparam logic [3:0] OFF_CTRL   = 4'hC;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    // The STATUS count field is only 4 bits wide; deeper FIFOs report 15.
    function automatic logic [3:0] sat_count4(input logic [31:0] c);
        return (c > 32'd15) ? 4'hF : c[3:0];
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous TX byte FIFO with occupancy count and reset flush
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push  = push && (!full || pop);
    assign do_pop   = pop && !empty;

    // Storage array: no reset, contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - MMIO 8N1 UART transmitter; optional TX-done interrupt under UART_TX_IRQ_EN
module uart_tx_mmio
    import uart_tx_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR   = 64'ha000_03f0,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wen,
    input  logic        i_ren,
    input  logic [63:0] i_addr,
    input  logic [63:0] i_wr_data,
    output logic [63:0] o_rd_data,
    output logic        o_tx
`ifdef UART_TX_IRQ_EN
    ,
    output logic        o_irq
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             sel;
    logic [3:0]       off;
    logic             wr_hit;
    logic             push;
    logic             pop;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    logic [15:0]      div_reg;
    logic             overflow;

    tx_state_e        state;
    logic [15:0]      baud_cnt;
    logic [15:0]      div_q;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             busy;

    logic             unused_wr_bits;
    assign unused_wr_bits = ^i_wr_data[63:16];

    assign sel    = (i_addr[63:4] == BASE_ADDR[63:4]);
    assign off    = i_addr[3:0];
    assign wr_hit = i_wen && sel;
    assign push   = wr_hit && (off == OFF_TXDATA);
    assign busy   = (state != S_IDLE);
    // Pop only when a new frame may begin: from idle, or at the last cycle of a stop bit.
    assign pop    = !fifo_empty &&
                    ((state == S_IDLE) || ((state == S_STOP) && (baud_cnt == 16'd0)));

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (i_wr_data[7:0]),
        .pop       (pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Divisor register and sticky overflow flag (write-one-to-clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg  <= DEFAULT_DIV;
            overflow <= 1'b0;
        end else begin
            if (wr_hit && (off == OFF_DIV)) begin
                div_reg <= i_wr_data[15:0];
            end
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end else if (wr_hit && (off == OFF_STATUS) && i_wr_data[STAT_OVF]) begin
                overflow <= 1'b0;
            end
        end
    end

    // Bit-timing FSM: each phase lasts div_q+1 cycles, div_q is frozen per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            div_q    <= DEFAULT_DIV;
            bit_idx  <= '0;
            shift    <= '0;
            o_tx     <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shift    <= fifo_dout;
                        div_q    <= div_reg;
                        baud_cnt <= div_reg;
                        state    <= S_START;
                        o_tx     <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_cnt == 16'd0) begin
                        baud_cnt <= div_q;
                        bit_idx  <= '0;
                        state    <= S_DATA;
                        o_tx     <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_cnt == 16'd0) begin
                        baud_cnt <= div_q;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                            o_tx  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= {1'b0, shift[7:1]};
                            o_tx    <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_cnt == 16'd0) begin
                        if (pop) begin
                            shift    <= fifo_dout;
                            div_q    <= div_reg;
                            baud_cnt <= div_reg;
                            state    <= S_START;
                            o_tx     <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            o_tx  <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    o_tx  <= 1'b1;
                end
            endcase
        end
    end

`ifdef UART_TX_IRQ_EN
    logic irq_en;

    // Interrupt enable and registered TX-done level (one cycle behind the line going idle).
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en <= 1'b0;
            o_irq  <= 1'b0;
        end else begin
            if (wr_hit && (off == OFF_CTRL)) begin
                irq_en <= i_wr_data[0];
            end
            o_irq <= irq_en && fifo_empty && !busy;
        end
    end
`endif

    // Combinational read mux; reads have no side effects.
    always_comb begin
        o_rd_data = '0;
        if (i_ren && sel) begin
            case (off)
                OFF_STATUS: begin
                    o_rd_data[STAT_FULL]  = fifo_full;
                    o_rd_data[STAT_EMPTY] = fifo_empty;
                    o_rd_data[STAT_BUSY]  = busy;
                    o_rd_data[STAT_OVF]   = overflow;
                    o_rd_data[7:4]        = sat_count4(32'(fifo_count));
                end
                OFF_DIV: begin
                    o_rd_data[15:0] = div_reg;
                end
`ifdef UART_TX_IRQ_EN
                OFF_CTRL: begin
                    o_rd_data[0] = irq_en;
                end
`endif
                default: begin
                    o_rd_data = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - randomized self-checking bench for uart_tx_mmio against a frame-level line model
module tb_uart_tx_mmio;

    localparam logic [63:0] BASE = 64'ha000_03f0;
    localparam logic [3:0]  A_TX = 4'h0;
    localparam logic [3:0]  A_ST = 4'h4;
    localparam logic [3:0]  A_DV = 4'h8;
    localparam logic [3:0]  A_CT = 4'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_wen;
    logic        i_ren;
    logic [63:0] i_addr;
    logic [63:0] i_wr_data;
    logic [63:0] o_rd_data;
    logic        o_tx;
`ifdef UART_TX_IRQ_EN
    logic        o_irq;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int base_div = 15;

    // stimulus schedule: one register write per cycle index at most
    int          ev_t[$];
    logic [3:0]  ev_off[$];
    logic [63:0] ev_data[$];

    // frame-level model output
    int          fr_t[$];
    int          fr_s[$];
    int          fr_e[$];
    int          fr_d[$];
    logic [7:0]  fr_b[$];

    always #5 clk = ~clk;

    uart_tx_mmio dut (
        .clk       (clk),
        .rst       (rst),
        .i_wen     (i_wen),
        .i_ren     (i_ren),
        .i_addr    (i_addr),
        .i_wr_data (i_wr_data),
        .o_rd_data (o_rd_data),
        .o_tx      (o_tx)
`ifdef UART_TX_IRQ_EN
        ,
        .o_irq     (o_irq)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [3:0] off, input logic [63:0] d);
        i_wen = 1'b1; i_addr = BASE + {60'd0, off}; i_wr_data = d;
        @(posedge clk); #1;
        i_wen = 1'b0;
    endtask

    task automatic rd_raw(input logic [63:0] a, output logic [63:0] d);
        i_ren = 1'b1; i_addr = a;
        #1;
        d = o_rd_data;
        i_ren = 1'b0;
    endtask

    task automatic rd(input logic [3:0] off, output logic [63:0] d);
        rd_raw(BASE + {60'd0, off}, d);
    endtask

    task automatic add_ev(input int t, input logic [3:0] off, input logic [63:0] d);
        ev_t.push_back(t); ev_off.push_back(off); ev_data.push_back(d);
    endtask

    // Frames start one cycle after their byte is written, or right after the previous
    // frame ends; each lasts 10*(DIV+1) cycles using the DIV visible just before it starts.
    // A write is dropped when 8 bytes are already waiting and no frame starts that cycle.
    task automatic build_model(output int ovf, output int last_end);
        int held, s, d, t;
        bit popping;
        fr_t.delete(); fr_s.delete(); fr_e.delete(); fr_d.delete(); fr_b.delete();
        ovf = 0; last_end = 0;
        foreach (ev_t[i]) begin
            if (ev_off[i] == A_TX) begin
                t = ev_t[i]; held = 0; popping = 0;
                foreach (fr_s[k]) begin
                    if (fr_t[k] <= t - 1 && fr_s[k] >= t) held++;
                    if (fr_s[k] == t) popping = 1;
                end
                if (held >= 8 && !popping) begin
                    ovf = 1;
                end else begin
                    s = (t + 1 > last_end + 1) ? t + 1 : last_end + 1;
                    d = base_div;
                    foreach (ev_t[j]) if (ev_off[j] == A_DV && ev_t[j] <= s - 1) d = int'(ev_data[j][15:0]);
                    last_end = s + 10 * (d + 1) - 1;
                    fr_t.push_back(t); fr_s.push_back(s); fr_e.push_back(last_end);
                    fr_d.push_back(d); fr_b.push_back(ev_data[i][7:0]);
                end
            end
        end
    endtask

    function automatic logic exp_tx(input int i);
        int pos;
        logic [7:0] b;
        foreach (fr_s[k]) begin
            if (i >= fr_s[k] && i <= fr_e[k]) begin
                pos = (i - fr_s[k]) / (fr_d[k] + 1);
                b = fr_b[k];
                if (pos == 0) return 1'b0;
                if (pos == 9) return 1'b1;
                return b[pos-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int i);
        foreach (fr_s[k]) if (i >= fr_s[k] && i <= fr_e[k]) return 1'b1;
        return 1'b0;
    endfunction

    // Plays the schedule, comparing o_tx and STATUS.busy every cycle until the line drains.
    task automatic run_sched(input string tag, input int chk_idx, input logic [7:0] chk_status);
        int ovf, last_end;
        logic [63:0] d;
        build_model(ovf, last_end);
        for (int t = 0; t < last_end + 3; t++) begin
            i_wen = 1'b0;
            foreach (ev_t[i]) begin
                if (ev_t[i] == t) begin
                    i_wen = 1'b1; i_addr = BASE + {60'd0, ev_off[i]}; i_wr_data = ev_data[i];
                end
            end
            @(posedge clk); #1;
            i_wen = 1'b0;
            check({tag, ".tx"}, {63'd0, o_tx}, {63'd0, exp_tx(t)});
            rd(A_ST, d);
            check({tag, ".busy"}, {63'd0, d[2]}, {63'd0, exp_busy(t)});
            if (t == chk_idx) check({tag, ".status_mid"}, d, {56'd0, chk_status});
        end
        rd(A_ST, d);
        check({tag, ".status_end"}, d, {60'd0, ovf[0], 3'b010});
        foreach (ev_t[i]) if (ev_off[i] == A_DV) base_div = int'(ev_data[i][15:0]);
        ev_t.delete(); ev_off.delete(); ev_data.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        int n, div, t;

        rst = 1'b1; i_wen = 1'b0; i_ren = 1'b0; i_addr = '0; i_wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("tx_in_reset", {63'd0, o_tx}, 64'd1);
        rd(A_ST, d);
        check("status_in_reset", d, 64'h2);
        rst = 1'b0;
        @(posedge clk); #1;
        rd(A_ST, d);
        check("status_after_reset", d, 64'h2);
        rd(A_DV, d);
        check("div_after_reset", d, 64'h000F);
        check("tx_after_reset", {63'd0, o_tx}, 64'd1);

        // decode: unmapped offsets, other windows and ren low all read zero
        rd(A_TX, d);
        check("txdata_reads_0", d, 64'd0);
        rd_raw(BASE + 64'h2, d);
        check("unmapped_reads_0", d, 64'd0);
        rd_raw(BASE + 64'h18, d);
        check("unselected_reads_0", d, 64'd0);
        i_ren = 1'b0; i_addr = BASE + 64'h8; #1;
        check("ren_low_reads_0", o_rd_data, 64'd0);
        i_wen = 1'b1; i_addr = BASE + 64'h18; i_wr_data = 64'h1234;
        @(posedge clk); #1; i_wen = 1'b0;
        wr(4'h6, 64'h5678);
        rd(A_DV, d);
        check("div_untouched", d, 64'h000F);
        wr(A_DV, 64'hFFFF_FFFF_0000_00AB);
        rd(A_DV, d);
        check("div_upper_zero", d, 64'h00AB);
        wr(A_CT, 64'h1);
        rd(A_CT, d);
`ifdef UART_TX_IRQ_EN
        check("ctrl_rw", d, 64'h1);
        wr(A_CT, 64'h0);
`else
        check("ctrl_reserved", d, 64'h0);
`endif
        base_div = 16'hAB;

        // DIV=3, single 0x55 frame
        add_ev(0, A_DV, 64'd3);
        add_ev(1, A_TX, 64'h55);
        run_sched("frame55", -1, 8'h0);

        // DIV=0, ten back-to-back writes; FIFO full after the ninth, tenth dropped
        add_ev(0, A_DV, 64'd0);
        for (int i = 0; i < 10; i++) add_ev(1 + i, A_TX, 64'h41 + 64'(i));
        run_sched("overflow", 9, 8'h85);
        wr(A_ST, 64'h0);
        rd(A_ST, d);
        check("ovf_w0_keeps", d, 64'hA);
        wr(A_ST, 64'h8);
        rd(A_ST, d);
        check("ovf_w1c", d, 64'h2);

        // DIV change during DATA applies only to the next frame
        add_ev(0, A_DV, 64'd7);
        add_ev(1, A_TX, 64'hC3);
        add_ev(30, A_DV, 64'd1);
        add_ev(31, A_TX, 64'h3C);
        run_sched("div_change", -1, 8'h0);

        // randomized rounds: random divisor, byte count, bytes and write gaps
        for (int r = 0; r < 6; r++) begin
            div = $urandom_range(0, 3);
            n = $urandom_range(1, 9);
            add_ev(0, A_DV, 64'(div));
            t = 1;
            for (int i = 0; i < n; i++) begin
                add_ev(t, A_TX, 64'($urandom_range(0, 255)));
                t = t + 1 + (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : 0);
            end
            run_sched("random", -1, 8'h0);
        end

        // reset in the middle of bit 4 with three bytes still queued
        wr(A_DV, 64'd3);
        for (int i = 0; i < 4; i++) wr(A_TX, 64'h00);
        repeat (19) @(posedge clk);
        #1;
        check("mid_frame_bit4", {63'd0, o_tx}, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("tx_after_mid_reset", {63'd0, o_tx}, 64'd1);
        rd(A_ST, d);
        check("status_after_mid_reset", d, 64'h2);
        rst = 1'b0;
        base_div = 15;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (o_tx !== 1'b1) n++;
        end
        check("line_idle_after_reset", 64'(n), 64'd0);
        rd(A_DV, d);
        check("div_reset_again", d, 64'h000F);

`ifdef UART_TX_IRQ_EN
        wr(A_CT, 64'h1);
        wr(A_DV, 64'd0);
        base_div = 0;
        repeat (2) @(posedge clk);
        #1;
        check("irq_idle_enabled", {63'd0, o_irq}, 64'd1);
        wr(A_TX, 64'h5A);
        n = 0;
        for (int i = 1; i <= 11; i++) begin
            @(posedge clk); #1;
            if (o_irq !== 1'b0) n++;
        end
        check("irq_low_while_busy", 64'(n), 64'd0);
        @(posedge clk); #1;
        check("irq_after_stop", {63'd0, o_irq}, 64'd1);
        wr(A_CT, 64'h0);
        @(posedge clk); #1;
        check("irq_disabled", {63'd0, o_irq}, 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
